// File: rtl/div_rem_unit_if.sv
// ---------------------------------------------------------------------------
// div_rem_unit_if
//   Bundle between the EX stage / stall-flush controller and the iterative
//   RV32M divide/remainder unit.
//
//   Signals
//     start              EX holds a valid DIV/DIVU/REM/REMU this cycle
//     op                 funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//     rs1, rs2           dividend, divisor
//     kill               ID-stage flush verdict: abort whatever is in flight
//     hold               L2 data-wait stall verdict: freezes the DONE hand-off
//     exe_stall_div_rem  stall request raised towards the controller
//     result             quotient or remainder, qualified by result_valid
//     result_valid       result may be captured into EX->MEM
//
//   Handshake: start is a level, not a pulse. It is sampled only in IDLE;
//   the same instruction keeps start high while the unit stalls the pipe.
//   exe_stall_div_rem stays high until the result is ready. result_valid is
//   high while the unit sits in DONE, and the hand-off completes on the first
//   rising edge of DONE that sees hold=0. kill overrides both outputs in the
//   cycle it is asserted.
//
//   Modports
//     master  pipeline / controller side
//     slave   divide unit side
// ---------------------------------------------------------------------------
interface div_rem_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            hold;
    logic            exe_stall_div_rem;
    logic [XLEN-1:0] result;
    logic            result_valid;

    modport master (
        output start, op, rs1, rs2, kill, hold,
        input  exe_stall_div_rem, result, result_valid
    );

    modport slave (
        input  start, op, rs1, rs2, kill, hold,
        output exe_stall_div_rem, result, result_valid
    );
endinterface

// File: rtl/div_rem_unit.sv
// ---------------------------------------------------------------------------
// div_rem_unit
//   Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the EX
//   stage. Restoring radix-2 division, one quotient bit per cycle, on operand
//   magnitudes; signs are re-applied when the result is formed.
//
//   Ports
//     clk        core clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        div_rem_unit_if.slave (start/op/rs1/rs2/kill/hold in,
//                exe_stall_div_rem/result/result_valid out)
//     dbg_state  current FSM state: 0 IDLE, 1 CALC, 2 DONE
//
//   Timing
//     normal   : stall for 1+XLEN cycles, result_valid in cycle XLEN+2
//     div by 0 / signed overflow : stall 1 cycle, result_valid in cycle 2
// ---------------------------------------------------------------------------
module div_rem_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    div_rem_unit_if.slave       bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [XLEN-1:0] dvd_q;     // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dvs_q;     // divisor magnitude
    logic            op_rem_q;  // 1: deliver remainder, 0: deliver quotient
    logic            neg_q_q;
    logic            neg_r_q;
    logic [XLEN-1:0] result_q;

    // ---------------------------------------------------------------------
    // Operand decode at start
    // ---------------------------------------------------------------------
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    assign is_signed   = ~bus.op[0];
    assign rs1_neg     = is_signed & bus.rs1[XLEN-1];
    assign rs2_neg     = is_signed & bus.rs2[XLEN-1];
    // -MIN_INT wraps back to MIN_INT, which is the correct unsigned magnitude.
    assign rs1_mag     = rs1_neg ? -bus.rs1 : bus.rs1;
    assign rs2_mag     = rs2_neg ? -bus.rs2 : bus.rs2;
    assign div_by_zero = (bus.rs2 == '0);
    assign overflow    = is_signed
                       & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}})
                       & (bus.rs2 == '1);

    // Divide by zero takes precedence: it is checked first and both cases
    // cannot occur together anyway (overflow needs rs2 = all ones).
    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = bus.op[1] ? bus.rs1 : '1;
        end else if (overflow) begin
            special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ---------------------------------------------------------------------
    // One restoring step
    // ---------------------------------------------------------------------
    // The trial value is one bit wider than the remainder so the borrow of
    // the subtraction lands in the MSB. When the trial fails, shifted is
    // always below the divisor, so it still fits back into XLEN bits.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] dvd_next;
    logic [XLEN-1:0] final_q;
    logic [XLEN-1:0] final_r;
    logic [XLEN-1:0] final_res;

    assign shifted   = {rem_q, dvd_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign q_bit     = ~diff[XLEN];
    assign rem_next  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign dvd_next  = {dvd_q[XLEN-2:0], q_bit};

    // Sign fix-up is applied to the values of the last step so the result
    // register is already final when DONE is entered.
    assign final_q   = neg_q_q ? -dvd_next : dvd_next;
    assign final_r   = neg_r_q ? -rem_next : rem_next;
    assign final_res = op_rem_q ? final_r : final_q;

    // ---------------------------------------------------------------------
    // FSM and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            // Flush: drop the operation, keep the last result for reference.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_rem_q <= bus.op[1];
                        neg_q_q  <= rs1_neg ^ rs2_neg;
                        neg_r_q  <= rs1_neg;
                        dvd_q    <= rs1_mag;
                        dvs_q    <= rs2_mag;
                        rem_q    <= '0;
                        cnt_q    <= CNT_W'(XLEN - 1);
                        if (div_by_zero || overflow) begin
                            result_q <= special_res;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // hold does not freeze the iteration; only DONE waits.
                    rem_q <= rem_next;
                    dvd_q <= dvd_next;
                    if (cnt_q == '0) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // start is the same instruction advancing; ignore it.
                    if (!bus.hold) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The stall is combinational so it is raised in the very cycle the
    // instruction reaches EX; kill masks both status outputs immediately.
    assign bus.exe_stall_div_rem = (((state == IDLE) & bus.start) | (state == CALC))
                                 & ~bus.kill;
    assign bus.result_valid      = (state == DONE) & ~bus.kill;
    assign bus.result            = result_q;
    assign dbg_state             = state;

endmodule

// File: tb/tb_div_rem_unit.sv
// ---------------------------------------------------------------------------
// tb_div_rem_unit
//   Self-checking bench for div_rem_unit: directed cases from the RV32M
//   corner rules followed by randomized operations, each compared with a
//   reference built from plain integer division.
// ---------------------------------------------------------------------------
module tb_div_rem_unit;

    localparam int XLEN = 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    div_rem_unit_if #(.XLEN(XLEN)) bus ();

    div_rem_unit #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [XLEN-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics straight from integer arithmetic.
    function automatic logic [XLEN-1:0] ref_result(input logic [1:0] o,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return o[1] ? 32'h0 : 32'h8000_0000;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic int ref_stall(input logic [1:0] o,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks (inputs change at negedge, outputs sampled 1 ns later)
    // ------------------------------------------------------------------
    task automatic drive_start(input logic [1:0] o, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs1   = a;
        bus.rs2   = b;
        #1;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Full operation: start held high like a stalled EX stage, optional
    // random hold during the calculation, optional hold_cycles in DONE.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input bit rand_hold, input int hold_cycles);
        int stall_cnt;
        int valid_cyc;
        logic [XLEN-1:0] exp_res;
        logic [XLEN-1:0] held;
        exp_q.push_back(ref_result(o, a, b));
        drive_start(o, a, b);
        stall_cnt = 0;
        valid_cyc = 0;
        for (int cyc = 1; cyc <= 80 && valid_cyc == 0; cyc++) begin
            if (cyc > 1) begin
                if (rand_hold) bus.hold = 1'($urandom_range(0, 1));
                step();
            end
            if (bus.result_valid) valid_cyc = cyc;
            else if (bus.exe_stall_div_rem) stall_cnt++;
        end
        bus.hold = 1'b0;
        exp_res = exp_q.pop_front();
        check({tag, "_valid_cycle"}, 32'(valid_cyc), 32'(ref_stall(o, a, b) + 1));
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(ref_stall(o, a, b)));
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_stall_in_done"}, 32'(bus.exe_stall_div_rem), 32'd0);
        if (hold_cycles > 0) begin
            held = bus.result;
            bus.hold = 1'b1;
            for (int i = 0; i < hold_cycles; i++) begin
                step();
                check({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
                check({tag, "_hold_result"}, bus.result, held);
            end
            bus.hold = 1'b0;
        end
        bus.start = 1'b0;
        step();
        check({tag, "_idle_after"}, 32'(dbg_state), 32'd0);
        check({tag, "_valid_dropped"}, 32'(bus.result_valid), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [1:0]      r_op;
        logic [XLEN-1:0] r_a;
        logic [XLEN-1:0] r_b;
        logic [XLEN-1:0] last_res;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.kill  = 1'b0;
        bus.hold  = 1'b0;

        // Reset state
        #1;
        check("rst_stall", 32'(bus.exe_stall_div_rem), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic unsigned and signed cases
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 0);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("div_m7_2_abs", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

        // Divide by zero and signed overflow
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1'b0, 0);
        run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 1'b0, 0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

        // Reset in the middle of a calculation
        run_op("divu_pre_rst", 2'b01, 32'd1000, 32'd3, 1'b0, 0);
        drive_start(2'b01, 32'hDEAD_BEEF, 32'd13);
        repeat (10) step();
        check("mid_calc_state", 32'(dbg_state), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("mid_rst_stall", 32'(bus.exe_stall_div_rem), 32'd0);
        check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_idle", 32'(dbg_state), 32'd0);
            check("post_rst_valid", 32'(bus.result_valid), 32'd0);
        end

        // kill at CALC iteration 15, then a fresh operation
        drive_start(2'b01, 32'hFFFF_0000, 32'd5);
        repeat (15) step();
        bus.kill = 1'b1;
        #1;
        check("kill_stall", 32'(bus.exe_stall_div_rem), 32'd0);
        check("kill_valid", 32'(bus.result_valid), 32'd0);
        bus.start = 1'b0;
        step();
        bus.kill = 1'b0;
        #1;
        check("kill_idle", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            check("kill_no_valid", 32'(bus.result_valid), 32'd0);
        end
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0, 0);

        // start together with kill in IDLE must not begin an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.rs1   = 32'd50;
        bus.rs2   = 32'd5;
        bus.kill  = 1'b1;
        #1;
        check("kill_start_stall", 32'(bus.exe_stall_div_rem), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        #1;
        check("kill_start_idle", 32'(dbg_state), 32'd0);

        // kill while the result is waiting under hold: kill wins
        last_res = bus.result;
        drive_start(2'b10, 32'd5, 32'd0);
        bus.hold = 1'b1;
        step();
        check("done_hold_valid", 32'(bus.result_valid), 32'd1);
        bus.kill = 1'b1;
        #1;
        check("kill_done_valid", 32'(bus.result_valid), 32'd0);
        bus.start = 1'b0;
        step();
        bus.kill = 1'b0;
        bus.hold = 1'b0;
        #1;
        check("kill_done_idle", 32'(dbg_state), 32'd0);
        check("kill_done_result", bus.result, 32'd5);
        check("kill_done_changed", 32'(bus.result != last_res), 32'd1);

        // hold for 4 cycles in DONE
        run_op("divu_hold", 2'b01, 32'd12345, 32'd11, 1'b0, 4);

        // Randomized operations, some with hold toggling during CALC
        for (int n = 0; n < 24; n++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 16));
                2: r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: r_a = 32'h8000_0000;
                1: r_a = 32'($urandom_range(0, 100));
                default: r_a = $urandom;
            endcase
            run_op("rand", r_op, r_a, r_b, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
